// File: rtl/dma_rom2ram_mc.sv
`default_nettype none
// ============================================================================
//  Module      : dma_rom2ram_mc
//  Description : Multi-channel ROM-to-RAM block copy engine. One beat is in
//                flight at a time and channels are served round-robin.
//  Revision    : 1.0 - initial release
// ============================================================================
module dma_rom2ram_mc #(
    parameter  int NUM_CH = 2,
    parameter  int DATA_W = 32,
    parameter  int ADDR_W = 32,
    parameter  int LEN_W  = 16,
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [ADDR_W-1:0] cfg_src,
    input  logic [ADDR_W-1:0] cfg_dst,
    input  logic [LEN_W-1:0]  cfg_len,
    output logic [NUM_CH-1:0] busy,
    output logic [NUM_CH-1:0] irq,
    input  logic [NUM_CH-1:0] irq_clr,
    output logic              rom_req_valid,
    input  logic              rom_req_ready,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic              rom_rsp_valid,
    input  logic [DATA_W-1:0] rom_rdata,
    output logic              ram_valid,
    input  logic              ram_ready,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata
);

    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(DATA_W / 8);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RD_REQ  = 2'd1,
        S_RD_WAIT = 2'd2,
        S_WR      = 2'd3
    } state_t;

    logic [ADDR_W-1:0] src_q [NUM_CH];
    logic [ADDR_W-1:0] dst_q [NUM_CH];
    logic [LEN_W-1:0]  rem_q [NUM_CH];
    logic [NUM_CH-1:0] busy_q, busy_d;
    logic [NUM_CH-1:0] irq_q, irq_d, irq_set;
    state_t            state_q;
    logic [CH_W-1:0]   sel_q;
    logic [CH_W-1:0]   rr_q;
    logic              rom_req_valid_q;
    logic              ram_valid_q;
    logic [ADDR_W-1:0] rom_addr_q;
    logic [ADDR_W-1:0] ram_addr_q;
    logic [DATA_W-1:0] ram_wdata_q;

    logic              cfg_in_range;
    logic              cfg_fire;
    logic              cfg_load;
    logic              cfg_zero;
    logic              wr_done;
    logic              last_beat;
    logic              pick_vld;
    logic [CH_W-1:0]   pick_ch;

    // Out-of-range channels are always ready so the request is silently dropped.
    always_comb begin
        cfg_in_range = (32'(cfg_ch) < 32'(NUM_CH));
        cfg_ready    = cfg_in_range ? ~busy_q[cfg_ch] : 1'b1;
        cfg_fire     = cfg_valid & cfg_ready & cfg_in_range;
        cfg_load     = cfg_fire & (cfg_len != '0);
        cfg_zero     = cfg_fire & (cfg_len == '0);
    end

    // Scan downward so the busy channel closest to the pointer wins.
    always_comb begin
        pick_vld = 1'b0;
        pick_ch  = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (busy_q[CH_W'((int'(rr_q) + k) % NUM_CH)]) begin
                pick_vld = 1'b1;
                pick_ch  = CH_W'((int'(rr_q) + k) % NUM_CH);
            end
        end
    end

    always_comb begin
        wr_done   = (state_q == S_WR) & ram_ready;
        last_beat = (rem_q[sel_q] == LEN_W'(1));
        busy_d    = busy_q;
        irq_set   = '0;
        if (cfg_load) begin
            busy_d[cfg_ch] = 1'b1;
        end
        if (cfg_zero) begin
            irq_set[cfg_ch] = 1'b1;
        end
        if (wr_done && last_beat) begin
            busy_d[sel_q]  = 1'b0;
            irq_set[sel_q] = 1'b1;
        end
        // A set landing on the same edge as a clear must win.
        irq_d = (irq_q & ~irq_clr) | irq_set;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                src_q[i] <= '0;
                dst_q[i] <= '0;
                rem_q[i] <= '0;
            end
            busy_q          <= '0;
            irq_q           <= '0;
            state_q         <= S_IDLE;
            sel_q           <= '0;
            rr_q            <= '0;
            rom_req_valid_q <= 1'b0;
            ram_valid_q     <= 1'b0;
            rom_addr_q      <= '0;
            ram_addr_q      <= '0;
            ram_wdata_q     <= '0;
        end else begin
            busy_q <= busy_d;
            irq_q  <= irq_d;

            // A loaded channel is never the selected one, so no index clash.
            if (cfg_load) begin
                src_q[cfg_ch] <= cfg_src;
                dst_q[cfg_ch] <= cfg_dst;
                rem_q[cfg_ch] <= cfg_len;
            end

            case (state_q)
                S_IDLE: begin
                    if (pick_vld) begin
                        sel_q           <= pick_ch;
                        rom_addr_q      <= src_q[pick_ch];
                        rom_req_valid_q <= 1'b1;
                        state_q         <= S_RD_REQ;
                    end
                end
                S_RD_REQ: begin
                    if (rom_req_ready) begin
                        rom_req_valid_q <= 1'b0;
                        state_q         <= S_RD_WAIT;
                    end
                end
                S_RD_WAIT: begin
                    if (rom_rsp_valid) begin
                        ram_wdata_q <= rom_rdata;
                        ram_addr_q  <= dst_q[sel_q];
                        ram_valid_q <= 1'b1;
                        state_q     <= S_WR;
                    end
                end
                S_WR: begin
                    if (ram_ready) begin
                        ram_valid_q  <= 1'b0;
                        src_q[sel_q] <= src_q[sel_q] + STEP;
                        dst_q[sel_q] <= dst_q[sel_q] + STEP;
                        rem_q[sel_q] <= rem_q[sel_q] - LEN_W'(1);
                        rr_q         <= (sel_q == CH_W'(NUM_CH - 1)) ? '0 : sel_q + 1'b1;
                        state_q      <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy          = busy_q;
    assign irq           = irq_q;
    assign rom_req_valid = rom_req_valid_q;
    assign rom_addr      = rom_addr_q;
    assign ram_valid     = ram_valid_q;
    assign ram_addr      = ram_addr_q;
    assign ram_wdata     = ram_wdata_q;

endmodule
`default_nettype wire
